// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state encoding and widths for alu_issue_wb.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int IDX_W  = 5;
   localparam int OP_W   = 5;

   // ALU opcodes 0-15 are decoded by the external ALU; 16-18 are handled here.
   localparam logic [OP_W-1:0] c_op_add   = 5'd0;
   localparam logic [OP_W-1:0] c_op_sub   = 5'd1;
   localparam logic [OP_W-1:0] c_op_addc  = 5'd2;
   localparam logic [OP_W-1:0] c_op_subb  = 5'd3;
   localparam logic [OP_W-1:0] c_op_mul   = 5'd4;
   localparam logic [OP_W-1:0] c_op_and   = 5'd5;
   localparam logic [OP_W-1:0] c_op_or    = 5'd6;
   localparam logic [OP_W-1:0] c_op_xor   = 5'd7;
   localparam logic [OP_W-1:0] c_op_shl   = 5'd8;
   localparam logic [OP_W-1:0] c_op_shr   = 5'd9;
   localparam logic [OP_W-1:0] c_op_sra   = 5'd10;
   localparam logic [OP_W-1:0] c_op_slt   = 5'd11;
   localparam logic [OP_W-1:0] c_op_sltu  = 5'd12;
   localparam logic [OP_W-1:0] c_op_not   = 5'd13;
   localparam logic [OP_W-1:0] c_op_passa = 5'd14;
   localparam logic [OP_W-1:0] c_op_passb = 5'd15;
   localparam logic [OP_W-1:0] c_op_load  = 5'd16;
   localparam logic [OP_W-1:0] c_op_store = 5'd17;
   localparam logic [OP_W-1:0] c_op_ldi   = 5'd18;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   function automatic logic op_sets_carry(input logic [OP_W-1:0] op);
      return (op <= c_op_subb);
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : Register file, two read ports, one write port, debug peek;
//               r0 reads as zero and ignores writes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
   import alu_pkg::*;
#(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int NREG   = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [IDX_W-1:0]  raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [IDX_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] r_rf [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_rf[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         r_rf[waddr] <= wdata;
      end
   end

   assign rdata_a  = (raddr_a  == '0) ? '0 : r_rf[raddr_a];
   assign rdata_b  = (raddr_b  == '0) ? '0 : r_rf[raddr_b];
   assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

endmodule : alu_regfile
`default_nettype wire

// File: rtl/alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_wb
// Description : 4-cycle issue/read/exec/writeback stage around an external
//               combinational ALU, with register file and data memory.
//               Define ALU_HI_WB_EN to latch the upper MUL product into hi.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_wb
   import alu_pkg::*;
#(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int NREG   = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_W-1:0]     in_op,
   input  logic [IDX_W-1:0]    in_rd,
   input  logic [IDX_W-1:0]    in_rs1,
   input  logic [IDX_W-1:0]    in_rs2,
   input  logic [DATA_W-1:0]   in_imm,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [OP_W-1:0]     alu_opcode,
   input  logic [2*DATA_W-1:0] alu_out,
   output logic                wb_valid,
   output logic [IDX_W-1:0]    wb_rd,
   output logic [DATA_W-1:0]   wb_data,
   output logic                carry,
   output logic [DATA_W-1:0]   hi,
   input  logic [IDX_W-1:0]    dbg_addr,
   output logic [DATA_W-1:0]   dbg_data
);

   state_t r_state;
   state_t w_next;

   logic w_in_ready;
   logic w_accept;
   logic w_do_read;
   logic w_do_exec;
   logic w_do_wb;
   logic w_rf_we;

   logic [OP_W-1:0]     r_op;
   logic [IDX_W-1:0]    r_rd;
   logic [IDX_W-1:0]    r_rs1;
   logic [IDX_W-1:0]    r_rs2;
   logic [DATA_W-1:0]   r_imm;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [2*DATA_W-1:0] r_res;
   logic [2*DATA_W-1:0] w_res;
   logic                r_wb_valid;
   logic [IDX_W-1:0]    r_wb_rd;
   logic [DATA_W-1:0]   r_wb_data;
   logic                r_carry;
   logic [DATA_W-1:0]   w_rdata_a;
   logic [DATA_W-1:0]   w_rdata_b;
   logic [DATA_W-1:0]   r_dmem [NREG];

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = (in_valid) ? S_READ : S_IDLE;
         S_READ:  w_next = S_EXEC;
         S_EXEC:  w_next = S_WB;
         S_WB:    w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready = (r_state == S_IDLE);
      w_accept   = w_in_ready && in_valid;
      w_do_read  = (r_state == S_READ);
      w_do_exec  = (r_state == S_EXEC);
      w_do_wb    = (r_state == S_WB);
      w_rf_we    = w_do_wb && (r_op != c_op_store);
   end

   // ---------------- register file ----------------
   alu_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (w_rf_we),
      .waddr    (r_rd),
      .wdata    (r_res[DATA_W-1:0]),
      .raddr_a  (r_rs1),
      .rdata_a  (w_rdata_a),
      .raddr_b  (r_rs2),
      .rdata_b  (w_rdata_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // ---------------- result select ----------------
   always_comb begin
      w_res = alu_out;
      case (r_op)
         c_op_load: w_res = {{DATA_W{1'b0}}, r_dmem[r_a[IDX_W-1:0]]};
         c_op_ldi:  w_res = {{DATA_W{1'b0}}, r_imm};
         default:   w_res = alu_out;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= '0;
         r_rd       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_imm      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_res      <= '0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_carry    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op  <= in_op;
            r_rd  <= in_rd;
            r_rs1 <= in_rs1;
            r_rs2 <= in_rs2;
            r_imm <= in_imm;
         end
         if (w_do_read) begin
            r_a <= w_rdata_a;
            r_b <= w_rdata_b;
         end
         if (w_do_exec) begin
            r_res <= w_res;
         end
         r_wb_valid <= w_do_wb;
         if (w_do_wb) begin
            r_wb_rd   <= r_rd;
            r_wb_data <= r_res[DATA_W-1:0];
            if (op_sets_carry(r_op)) begin
               r_carry <= r_res[DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_dmem[i] <= '0;
         end
      end else if (w_do_exec && (r_op == c_op_store)) begin
         r_dmem[r_a[IDX_W-1:0]] <= r_b;
      end
   end

   // ---------------- upper product word ----------------
`ifdef ALU_HI_WB_EN
   logic [DATA_W-1:0] r_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= '0;
      end else if (w_do_wb && (r_op == c_op_mul)) begin
         r_hi <= r_res[2*DATA_W-1:DATA_W];
      end
   end

   assign hi = r_hi;
`else
   logic w_unused_res_hi;

   assign w_unused_res_hi = ^r_res[2*DATA_W-1:DATA_W+1];
   assign hi              = '0;
`endif

   assign in_ready   = w_in_ready;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_opcode = r_op;
   assign wb_valid   = r_wb_valid;
   assign wb_rd      = r_wb_rd;
   assign wb_data    = r_wb_data;
   assign carry      = r_carry;

endmodule : alu_issue_wb
`default_nettype wire
